// File: rtl/scmp_useq_pkg.sv
// Shared types and constants for the SC/MP microcode sequencer.
// Defines the next-address modes, condition indices and DLY cycle-count terms.
package scmp_useq_pkg;

   typedef enum logic [2:0] {
      NX_SEQ  = 3'd0,
      NX_JMP  = 3'd1,
      NX_CALL = 3'd2,
      NX_RET  = 3'd3,
      NX_BR   = 3'd4,
      NX_DISP = 3'd5,
      NX_DLY  = 3'd6,
      NX_HALT = 3'd7
   } nxt_t;

   localparam int unsigned CondAccZero = 0;
   localparam int unsigned CondCarry   = 1;
   localparam int unsigned CondAccSign = 2;
   localparam int unsigned CondBusRdy  = 3;

   // DLY duration in microcycles: DlyBase + 2*AC + DlyMul*disp
   localparam int unsigned DlyBase = 13;
   localparam int unsigned DlyMul  = 514;

endpackage

// File: rtl/scmp_useq_stack.sv
// Return-address LIFO for the microcode sequencer.
// Only the stack pointer is reset; entry contents are don't-care until written.
module scmp_useq_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned SpW  = $clog2(DEPTH + 1);
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SpW-1:0]   sp_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IdxW-1:0]  top_idx;
   logic [IdxW-1:0]  wr_idx;

   assign full    = (sp_q == SpW'(DEPTH));
   assign empty   = (sp_q == '0);
   assign top_idx = IdxW'(sp_q - 1'b1);
   assign wr_idx  = IdxW'(sp_q);
   assign rd_data = mem_q[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q <= '0;
      end else if (push && !full) begin
         sp_q <= sp_q + 1'b1;
      end else if (pop && !empty) begin
         sp_q <= sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/scmp_useq.sv
// SC/MP microcode sequencer: produces the microcode ROM address each microcycle,
// with return stack, conditional branch, interrupt dispatch, DLY countdown and HALT wait.
module scmp_useq
   import scmp_useq_pkg::*;
#(
   parameter int unsigned      UPC_W       = 8,
   parameter int unsigned      STACK_DEPTH = 4,
   parameter int unsigned      DLY_W       = 18,
   parameter logic [UPC_W-1:0] RESET_VEC   = '0,
   parameter logic [UPC_W-1:0] INT_VEC     = UPC_W'('hF0)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mc_nxt,
   input  logic [UPC_W-1:0] mc_addr,
   input  logic [1:0]       mc_csel,
   input  logic [3:0]       cond,
   input  logic [UPC_W-1:0] disp_pc,
   input  logic             irq,
   input  logic             cont,
   input  logic [7:0]       dly_ac,
   input  logic [7:0]       dly_disp,
   input  logic             err_clr,
   output logic [UPC_W-1:0] upc,
   output logic             int_ack,
   output logic             dly_active,
   output logic             halted,
   output logic             stk_ovf,
   output logic             stk_unf
);

   logic [UPC_W-1:0] upc_q, upc_d, upc_inc;
   logic [DLY_W-1:0] cnt_q, cnt_d, dly_n;
   logic             dly_q, dly_d;
   logic             halt_q, halt_d;
   logic             ack_q, ack_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push, pop, full, empty;
   logic [UPC_W-1:0] pop_data;
   nxt_t             mode;

   assign mode    = nxt_t'(mc_nxt);
   assign upc_inc = upc_q + 1'b1;
   assign dly_n   = DLY_W'(DlyBase) + (DLY_W'(dly_ac) << 1) + DLY_W'(dly_disp) * DLY_W'(DlyMul);

   scmp_useq_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (UPC_W)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (upc_inc),
      .rd_data (pop_data),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      upc_d  = upc_q;
      cnt_d  = cnt_q;
      dly_d  = dly_q;
      halt_d = halt_q;
      ack_d  = 1'b0;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      push   = 1'b0;
      pop    = 1'b0;
      if (en) begin
         // Clear first so that a same-cycle error set takes precedence.
         if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         if (dly_q) begin
            // cnt holds the remaining active cycles, including this one.
            if (cnt_q == DLY_W'(1)) begin
               dly_d = 1'b0;
               cnt_d = '0;
               upc_d = upc_inc;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end else if (halt_q) begin
            if (cont) begin
               halt_d = 1'b0;
               upc_d  = upc_inc;
            end
         end else begin
            unique case (mode)
               NX_SEQ:  upc_d = upc_inc;
               NX_JMP:  upc_d = mc_addr;
               NX_CALL: begin
                  upc_d = mc_addr;
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end
               NX_RET: begin
                  if (empty) begin
                     upc_d = upc_inc;
                     unf_d = 1'b1;
                  end else begin
                     pop   = 1'b1;
                     upc_d = pop_data;
                  end
               end
               NX_BR:   upc_d = cond[mc_csel] ? mc_addr : upc_inc;
               NX_DISP: begin
                  if (irq) begin
                     upc_d = INT_VEC;
                     ack_d = 1'b1;
                  end else begin
                     upc_d = disp_pc;
                  end
               end
               NX_DLY: begin
                  cnt_d = dly_n - 1'b1;
                  dly_d = 1'b1;
               end
               NX_HALT: halt_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upc_q  <= RESET_VEC;
         cnt_q  <= '0;
         dly_q  <= 1'b0;
         halt_q <= 1'b0;
         ack_q  <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         upc_q  <= upc_d;
         cnt_q  <= cnt_d;
         dly_q  <= dly_d;
         halt_q <= halt_d;
         ack_q  <= ack_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   assign upc        = upc_q;
   assign int_ack    = ack_q & en;
   assign dly_active = dly_q;
   assign halted     = halt_q;
   assign stk_ovf    = ovf_q;
   assign stk_unf    = unf_q;

endmodule

// File: tb/tb_scmp_useq.sv
// Directed self-checking bench for scmp_useq with hand-computed expectations.
module tb_scmp_useq;
   import scmp_useq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en = 1'b1;
   logic [2:0] mc_nxt = 3'd0;
   logic [7:0] mc_addr = 8'h00;
   logic [1:0] mc_csel = 2'd0;
   logic [3:0] cond = 4'h0;
   logic [7:0] disp_pc = 8'h00;
   logic       irq = 1'b0;
   logic       cont = 1'b0;
   logic [7:0] dly_ac = 8'h00;
   logic [7:0] dly_disp = 8'h00;
   logic       err_clr = 1'b0;
   logic [7:0] upc;
   logic       int_ack, dly_active, halted, stk_ovf, stk_unf;

   int checks = 0;
   int errors = 0;

   scmp_useq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mc_nxt     (mc_nxt),
      .mc_addr    (mc_addr),
      .mc_csel    (mc_csel),
      .cond       (cond),
      .disp_pc    (disp_pc),
      .irq        (irq),
      .cont       (cont),
      .dly_ac     (dly_ac),
      .dly_disp   (dly_disp),
      .err_clr    (err_clr),
      .upc        (upc),
      .int_ack    (int_ack),
      .dly_active (dly_active),
      .halted     (halted),
      .stk_ovf    (stk_ovf),
      .stk_unf    (stk_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [2:0] nxt, input logic [7:0] addr);
      mc_nxt  = nxt;
      mc_addr = addr;
      @(posedge clk);
      #1;
   endtask

   // Issues NX_DLY, then drives ignored JMPs while counting cycles with dly_active high.
   task automatic dly_run(input string tag, input logic [7:0] ac, input logic [7:0] dp,
                          input int low_at, input int low_len, input int exp_act);
      logic [7:0] u, u1;
      int         act, k, held_bad;
      u        = upc;
      u1       = u + 8'd1;
      dly_ac   = ac;
      dly_disp = dp;
      step(NX_DLY, 8'h00);
      chk({tag, " issue active"}, dly_active, 1);
      act      = 0;
      k        = 0;
      held_bad = 0;
      while (dly_active === 1'b1 && k < 3000) begin
         act++;
         if (upc !== u) held_bad++;
         en = !(k >= low_at && k < low_at + low_len);
         step(NX_JMP, 8'hAA);
         k++;
      end
      en = 1'b1;
      chk({tag, " active cycles"}, act, exp_act);
      chk({tag, " upc held"}, held_bad, 0);
      chk({tag, " upc after"}, upc, u1);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset upc", upc, 8'h00);
      chk("reset halted", halted, 0);
      chk("reset dly_active", dly_active, 0);
      chk("reset int_ack", int_ack, 0);
      chk("reset stk_ovf", stk_ovf, 0);
      chk("reset stk_unf", stk_unf, 0);
      rst_n = 1'b1;

      step(NX_SEQ, 8'h00); chk("seq 1", upc, 8'h01);
      step(NX_SEQ, 8'h00); chk("seq 2", upc, 8'h02);
      step(NX_SEQ, 8'h00); chk("seq 3", upc, 8'h03);
      step(NX_JMP, 8'hFF); chk("jmp ff", upc, 8'hFF);
      step(NX_SEQ, 8'h00); chk("seq wrap", upc, 8'h00);

      step(NX_JMP, 8'h10);  chk("jmp 10", upc, 8'h10);
      step(NX_CALL, 8'h40); chk("call 40", upc, 8'h40);
      step(NX_RET, 8'h00);  chk("ret 11", upc, 8'h11);

      step(NX_CALL, 8'h50); chk("nest call1", upc, 8'h50);
      step(NX_CALL, 8'h60); chk("nest call2", upc, 8'h60);
      step(NX_CALL, 8'h70); chk("nest call3", upc, 8'h70);
      step(NX_CALL, 8'h80); chk("nest call4", upc, 8'h80);
      chk("ovf before full push", stk_ovf, 0);
      step(NX_CALL, 8'h90); chk("nest call5", upc, 8'h90);
      chk("ovf set", stk_ovf, 1);
      step(NX_RET, 8'h00); chk("ret1", upc, 8'h71);
      step(NX_RET, 8'h00); chk("ret2", upc, 8'h61);
      step(NX_RET, 8'h00); chk("ret3", upc, 8'h51);
      step(NX_RET, 8'h00); chk("ret4", upc, 8'h12);
      chk("unf before empty pop", stk_unf, 0);
      step(NX_RET, 8'h00); chk("ret5 empty", upc, 8'h13);
      chk("unf set", stk_unf, 1);
      err_clr = 1'b1;
      step(NX_SEQ, 8'h00); chk("clr upc", upc, 8'h14);
      chk("clr ovf", stk_ovf, 0);
      chk("clr unf", stk_unf, 0);
      step(NX_RET, 8'h00); chk("set beats clr upc", upc, 8'h15);
      chk("set beats clr unf", stk_unf, 1);
      step(NX_SEQ, 8'h00); chk("clr again", stk_unf, 0);
      err_clr = 1'b0;

      disp_pc = 8'h22;
      step(NX_DISP, 8'h00); chk("disp upc", upc, 8'h22);
      chk("disp no ack", int_ack, 0);
      irq = 1'b1;
      step(NX_DISP, 8'h00); chk("int upc", upc, 8'hF0);
      chk("int ack high", int_ack, 1);
      irq = 1'b0;
      step(NX_SEQ, 8'h00); chk("after int upc", upc, 8'hF1);
      chk("int ack low", int_ack, 0);

      mc_csel = 2'd1;
      cond    = 4'b0010;
      step(NX_BR, 8'h30); chk("br taken", upc, 8'h30);
      cond = 4'b0000;
      step(NX_BR, 8'h30); chk("br not taken", upc, 8'h31);
      mc_csel = 2'd3;
      cond    = 4'b1000;
      step(NX_BR, 8'h05); chk("br csel3", upc, 8'h05);
      cond = 4'b0000;

      en = 1'b0;
      step(NX_SEQ, 8'h00); chk("en low hold", upc, 8'h05);
      en = 1'b1;
      step(NX_SEQ, 8'h00); chk("en high seq", upc, 8'h06);

      dly_run("dly min", 8'h00, 8'h00, 9999, 0, 12);
      dly_run("dly mid", 8'h10, 8'h02, 9999, 0, 1072);
      dly_run("dly en gap", 8'h00, 8'h00, 5, 3, 15);
      chk("dly end upc", upc, 8'h09);

      cont = 1'b1;
      step(NX_HALT, 8'h00); chk("halt issue upc", upc, 8'h09);
      chk("halt issue flag", halted, 1);
      cont = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(NX_SEQ, 8'h00);
         chk("halt wait upc", upc, 8'h09);
         chk("halt wait flag", halted, 1);
      end
      cont = 1'b1;
      step(NX_SEQ, 8'h00); chk("halt cont upc", upc, 8'h0A);
      chk("halt cont flag", halted, 0);
      cont = 1'b0;

      step(NX_HALT, 8'h00); chk("halt2 flag", halted, 1);
      irq = 1'b1;
      step(NX_DISP, 8'h00); chk("irq in halt upc", upc, 8'h0A);
      chk("irq in halt ack", int_ack, 0);
      irq = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("halt reset upc", upc, 8'h00);
      chk("halt reset flag", halted, 0);
      rst_n = 1'b1;
      step(NX_SEQ, 8'h00); chk("post reset seq", upc, 8'h01);

      step(NX_DLY, 8'h00);
      step(NX_SEQ, 8'h00);
      step(NX_SEQ, 8'h00);
      chk("dly pre reset", dly_active, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("dly reset active", dly_active, 0);
      chk("dly reset upc", upc, 8'h00);
      rst_n = 1'b1;
      step(NX_SEQ, 8'h00); chk("dly reset seq1", upc, 8'h01);
      step(NX_SEQ, 8'h00); chk("dly reset seq2", upc, 8'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
